// File: rtl/cr16_pkg.sv
// Shared CR16 definitions: opcode/function encodings, ALU codes, mux selects,
// condition codes, controller states and the EXEC-cycle decode function.
package cr16_pkg;

  localparam int SIZE = 16;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_LD_WB  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  // Major opcodes; ALU-immediate opcodes reuse the FN_* values below
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_LSH   = 4'b1000;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] FN_AND = 4'b0001;
  localparam logic [3:0] FN_OR  = 4'b0010;
  localparam logic [3:0] FN_ADD = 4'b0101;
  localparam logic [3:0] FN_XOR = 4'b0111;
  localparam logic [3:0] FN_SUB = 4'b1001;
  localparam logic [3:0] FN_CMP = 4'b1011;
  localparam logic [3:0] FN_MOV = 4'b1101;

  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_JAL  = 4'b1000;
  localparam logic [3:0] EXT_JCND = 4'b1100;
  localparam logic [3:0] EXT_LSHR = 4'b0100;
  localparam logic [3:0] EXT_LSHI = 4'b0000;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_XOR = 4'd2;
  localparam logic [3:0] ALU_ADD = 4'd3;
  localparam logic [3:0] ALU_SUB = 4'd4;
  localparam logic [3:0] ALU_CMP = 4'd5;
  localparam logic [3:0] ALU_LSH = 4'd6;

  localparam logic [1:0] PCM_INC  = 2'd0;
  localparam logic [1:0] PCM_RSRC = 2'd1;
  localparam logic [1:0] PCM_ALU  = 2'd2;
  localparam logic [1:0] MAM_PC   = 2'd0;
  localparam logic [1:0] MAM_RSRC = 2'd1;
  localparam logic [1:0] RWM_MEM  = 2'd0;
  localparam logic [1:0] RWM_PC1  = 2'd1;
  localparam logic [1:0] RWM_MOV  = 2'd2;
  localparam logic [1:0] RWM_LUI  = 2'd3;
  localparam logic [1:0] A2M_RSRC = 2'd0;
  localparam logic [1:0] A2M_ZEXT = 2'd1;
  localparam logic [1:0] A2M_SEXT = 2'd2;
  localparam logic       A1M_PC   = 1'b1;
  localparam logic       MOVM_ALU = 1'b1;

  localparam logic [3:0] CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3;
  localparam logic [3:0] CC_HI = 4'd4,  CC_LS = 4'd5,  CC_GT = 4'd6,  CC_LE = 4'd7;
  localparam logic [3:0] CC_FS = 4'd8,  CC_FC = 4'd9,  CC_LO = 4'd10, CC_HS = 4'd11;
  localparam logic [3:0] CC_LT = 4'd12, CC_GE = 4'd13, CC_UC = 4'd14, CC_NV = 4'd15;

  typedef struct packed {
    logic       legal;
    logic       use_alu;
    logic       rfen;
    logic       psren;
    logic       setznl;
    logic       pcen;
    logic       memw1en;
    logic       movm;
    logic       a1m;
    logic [1:0] pcm;
    logic [1:0] mam;
    logic [1:0] a2m;
    logic [1:0] rwm;
    logic [3:0] aluop;
  } ctrl_t;

  // {valid, aluOp} for a function code shared by R-type ext and I-type op
  function automatic logic [4:0] alu_code(input logic [3:0] fn);
    case (fn)
      FN_AND:  return {1'b1, ALU_AND};
      FN_OR:   return {1'b1, ALU_OR};
      FN_XOR:  return {1'b1, ALU_XOR};
      FN_ADD:  return {1'b1, ALU_ADD};
      FN_SUB:  return {1'b1, ALU_SUB};
      FN_CMP:  return {1'b1, ALU_CMP};
      default: return 5'b0;
    endcase
  endfunction

  // hi = instr[15:4]: op=[11:8], rdst=[7:4], ext=[3:0]
  function automatic ctrl_t exec_decode(input logic [11:0] hi, input logic taken);
    ctrl_t      c;
    logic [3:0] op, ext, code;
    logic [4:0] ac;
    op   = hi[11:8];
    ext  = hi[3:0];
    code = (op == OP_RTYPE) ? ext : op;
    ac   = alu_code(code);
    c       = '0;
    c.legal = 1'b1;
    c.pcen  = 1'b1;
    case (op)
      OP_LUI: begin
        c.rfen = 1'b1;
        c.rwm  = RWM_LUI;
      end
      OP_LSH: begin
        c.legal   = (ext == EXT_LSHR) || (ext == EXT_LSHI);
        c.use_alu = 1'b1;
        c.aluop   = ALU_LSH;
        c.rfen    = 1'b1;
        c.rwm     = RWM_MOV;
        c.movm    = MOVM_ALU;
        c.a2m     = (ext == EXT_LSHR) ? A2M_RSRC : A2M_ZEXT;
      end
      OP_MEM: begin
        case (ext)
          EXT_LOAD: begin
            c.mam  = MAM_RSRC;
            c.pcen = 1'b0;
          end
          EXT_STOR: begin
            c.mam     = MAM_RSRC;
            c.memw1en = 1'b1;
          end
          EXT_JAL: begin
            c.rfen = 1'b1;
            c.rwm  = RWM_PC1;
            c.pcm  = PCM_RSRC;
          end
          EXT_JCND: c.pcm = taken ? PCM_RSRC : PCM_INC;
          default:  c.legal = 1'b0;
        endcase
      end
      OP_BCOND: begin
        c.a1m     = A1M_PC;
        c.a2m     = A2M_SEXT;
        c.use_alu = 1'b1;
        c.aluop   = ALU_ADD;
        c.pcm     = taken ? PCM_ALU : PCM_INC;
      end
      default: begin
        if (code == FN_MOV) begin
          c.rfen = 1'b1;
          c.rwm  = RWM_MOV;
          c.a2m  = (op == OP_RTYPE) ? A2M_RSRC : A2M_SEXT;
        end else if (ac[4]) begin
          c.use_alu = 1'b1;
          c.aluop   = ac[3:0];
          c.rfen    = (code != FN_CMP);
          c.psren   = 1'b1;
          c.setznl  = 1'b1;
          c.rwm     = RWM_MOV;
          c.movm    = MOVM_ALU;
          c.a2m     = (op == OP_RTYPE) ? A2M_RSRC : A2M_SEXT;
        end else begin
          c.legal = 1'b0;
        end
      end
    endcase
    // unknown encodings collapse to a plain PC+1
    if (!c.legal) begin
      c      = '0;
      c.pcen = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/cr16_controller_cond_eval.sv
// Branch/jump condition evaluation against committed PSR flags.
module cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [1:0] flags1,
  input  logic [2:0] flags2,
  output logic       taken
);
  logic c, f, z, l, n;
  assign {c, f}    = flags1;
  assign {z, l, n} = flags2;

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_CS: taken = c;
      CC_CC: taken = !c;
      CC_HI: taken = l;
      CC_LS: taken = !l;
      CC_GT: taken = n;
      CC_LE: taken = !n;
      CC_FS: taken = f;
      CC_FC: taken = !f;
      CC_LO: taken = !l && !z;
      CC_HS: taken = l || z;
      CC_LT: taken = !n && !z;
      CC_GE: taken = n || z;
      CC_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/cr16_controller.sv
// CR16 multicycle control FSM: FETCH -> DECODE -> EXEC [-> LD_WB].
// Define CTRL_ILLEGAL_TRAP_EN to halt on unknown encodings instead of NOP.
module cr16_controller
  import cr16_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] instr,
  input  logic [1:0]      flags1,
  input  logic [2:0]      flags2,
  output logic            MemW1en,
  output logic            MemW2en,
  output logic            RFen,
  output logic            PSRen,
  output logic            PCen,
  output logic            INSTRen,
  output logic            Movm,
  output logic            A1m,
  output logic            setZNL,
  output logic [1:0]      PCm,
  output logic [1:0]      MAm,
  output logic [1:0]      A2m,
  output logic [1:0]      RWm,
  output logic [3:0]      aluOp,
  output logic            halted
);
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  state_t     state, nstate;
  ctrl_t      dec;
  logic       taken;
  logic [3:0] aluop_q;
  logic       unused_rsrc;

  cond_eval u_cond (
    .cond   (instr[11:8]),
    .flags1 (flags1),
    .flags2 (flags2),
    .taken  (taken)
  );

  assign dec         = exec_decode(instr[15:4], taken);
  assign unused_rsrc = ^instr[3:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= nstate;
  end

  // aluOp is held between ALU-using EXEC cycles
  always_ff @(posedge clk) begin
    if (reset)                                           aluop_q <= '0;
    else if (state == S_EXEC && dec.legal && dec.use_alu) aluop_q <= dec.aluop;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_FETCH:  nstate = S_DECODE;
      S_DECODE: nstate = S_EXEC;
      S_EXEC: begin
        if (dec.legal && dec.mam == MAM_RSRC && !dec.memw1en) nstate = S_LD_WB;
        else if (!dec.legal && TRAP)                          nstate = S_HALT;
        else                                                  nstate = S_FETCH;
      end
      S_LD_WB:  nstate = S_FETCH;
      S_HALT:   nstate = S_HALT;
      default:  nstate = S_FETCH;
    endcase
  end

  always_comb begin
    {MemW1en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL} = '0;
    PCm   = PCM_INC;
    MAm   = MAM_PC;
    A2m   = A2M_RSRC;
    RWm   = RWM_MEM;
    aluOp = reset ? 4'd0 : aluop_q;
    if (!reset) begin
      case (state)
        S_DECODE: INSTRen = 1'b1;
        S_EXEC: begin
          if (dec.legal || !TRAP) begin
            RFen    = dec.rfen;
            PSRen   = dec.psren;
            setZNL  = dec.setznl;
            PCen    = dec.pcen;
            MemW1en = dec.memw1en;
            Movm    = dec.movm;
            A1m     = dec.a1m;
            PCm     = dec.pcm;
            MAm     = dec.mam;
            A2m     = dec.a2m;
            RWm     = dec.rwm;
            if (dec.use_alu) aluOp = dec.aluop;
          end
        end
        S_LD_WB: begin
          MAm  = MAM_RSRC;
          RWm  = RWM_MEM;
          RFen = 1'b1;
          PCen = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign MemW2en = 1'b0;

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign halted = (state == S_HALT) && !reset;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cr16_controller.sv
// Self-checking bench for cr16_controller: vector table + EXEC-cycle scoreboard.
module tb_cr16_controller;
  import cr16_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instr = '0;
  logic [1:0]  flags1 = '0;
  logic [2:0]  flags2 = '0;
  logic MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL, halted;
  logic [1:0] PCm, MAm, A2m, RWm;
  logic [3:0] aluOp;

  always #5 clk = ~clk;

  cr16_controller #(.SIZE(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .flags1(flags1), .flags2(flags2),
    .MemW1en(MemW1en), .MemW2en(MemW2en), .RFen(RFen), .PSRen(PSRen), .PCen(PCen),
    .INSTRen(INSTRen), .Movm(Movm), .A1m(A1m), .setZNL(setZNL),
    .PCm(PCm), .MAm(MAm), .A2m(A2m), .RWm(RWm), .aluOp(aluOp), .halted(halted)
  );

  typedef struct packed {
    logic memw1en, memw2en, rfen, psren, pcen, instren, movm, a1m, setznl;
    logic [1:0] pcm, mam, a2m, rwm;
    logic [3:0] aluop;
    logic halted;
  } ctl_t;

  typedef struct packed {
    logic [47:0] nm;
    logic [15:0] instr;
    logic [1:0]  f1;
    logic [2:0]  f2;
    logic        care;
    ctl_t        exp;
  } vec_t;

  ctl_t act;
  assign act = {MemW1en, MemW2en, RFen, PSRen, PCen, INSTRen, Movm, A1m, setZNL,
                PCm, MAm, A2m, RWm, aluOp, halted};

  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_dec = -1, memw_cnt = 0;
  bit w2_seen = 1'b0, prev_ie = 1'b0;
  logic [3:0] last_alu = '0;
  vec_t tbl[$];
  vec_t sbq[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  function automatic ctl_t E(input logic pcen, rf, psr, mw, mv, a1,
                             input logic [1:0] pcm, mam, a2m, rwm, input logic [3:0] alu);
    ctl_t e;
    e = '0;
    e.pcen = pcen; e.rfen = rf; e.psren = psr; e.setznl = psr; e.memw1en = mw;
    e.movm = mv; e.a1m = a1; e.pcm = pcm; e.mam = mam; e.a2m = a2m; e.rwm = rwm;
    e.aluop = alu;
    return e;
  endfunction

  function automatic vec_t V(input logic [47:0] nm, input logic [15:0] i,
                             input logic [1:0] f1, input logic [2:0] f2,
                             input logic care, input ctl_t e);
    vec_t v;
    v.nm = nm; v.instr = i; v.f1 = f1; v.f2 = f2; v.care = care; v.exp = e;
    return v;
  endfunction

  function automatic bit cref(input logic [3:0] c, input logic [1:0] f1, input logic [2:0] f2);
    bit C, F, Z, L, N;
    C = f1[1]; F = f1[0]; Z = f2[2]; L = f2[1]; N = f2[0];
    case (c)
      4'd0: return Z;          4'd1: return !Z;
      4'd2: return C;          4'd3: return !C;
      4'd4: return L;          4'd5: return !L;
      4'd6: return N;          4'd7: return !N;
      4'd8: return F;          4'd9: return !F;
      4'd10: return !L && !Z;  4'd11: return L || Z;
      4'd12: return !N && !Z;  4'd13: return N || Z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // EXEC is the cycle right after INSTRen; compare against the queued expectation
  always @(negedge clk) begin
    ctl_t e;
    vec_t v;
    if (MemW1en) memw_cnt++;
    if (MemW2en) w2_seen = 1'b1;
    if (reset) last_alu = '0;
    if (prev_ie && !reset) begin
      if (sbq.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        v = sbq.pop_front();
        e = v.exp;
        if (v.care) last_alu = e.aluop;
        else        e.aluop  = last_alu;
        n_chk++;
        if (act === e) n_pass++;
        else $display("FAIL exec %s (instr %h f1 %b f2 %b): got %h expected %h",
                      v.nm, v.instr, v.f1, v.f2, act, e);
      end
    end
    prev_ie = INSTRen;
  end

  task automatic do_instr(input vec_t v, input int gap);
    int k;
    k = 0;
    @(negedge clk);
    while (!INSTRen && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!INSTRen) begin
      chk("decode_timeout", 32'd0, 32'd1);
      return;
    end
    instr = v.instr; flags1 = v.f1; flags2 = v.f2;
    sbq.push_back(v);
    if (gap > 0 && last_dec >= 0) chk("decode_gap", cyc - last_dec, gap);
    last_dec = cyc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v, addi;
    ctl_t e;
    int m0;
    addi = V("ADDI", 16'h5105, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,2,2, ALU_ADD));

    tbl.push_back(V("ADD",  16'h0152, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,0,2, ALU_ADD)));
    tbl.push_back(V("AND",  16'h0113, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,0,2, ALU_AND)));
    tbl.push_back(V("OR",   16'h0123, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,0,2, ALU_OR)));
    tbl.push_back(V("XOR",  16'h0173, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,0,2, ALU_XOR)));
    tbl.push_back(V("SUB",  16'h0193, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,0,2, ALU_SUB)));
    tbl.push_back(V("ANDI", 16'h1105, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,2,2, ALU_AND)));
    tbl.push_back(V("MOV",  16'h01D2, 2'b00, 3'b000, 1'b0, E(1,1,0,0,0,0, 0,0,0,2, 4'd0)));
    tbl.push_back(V("ORI",  16'h2105, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,2,2, ALU_OR)));
    tbl.push_back(V("XORI", 16'h7105, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,2,2, ALU_XOR)));
    tbl.push_back(V("MOVI", 16'hD1FF, 2'b00, 3'b000, 1'b0, E(1,1,0,0,0,0, 0,0,2,2, 4'd0)));
    tbl.push_back(V("SUBI", 16'h9105, 2'b00, 3'b000, 1'b1, E(1,1,1,0,1,0, 0,0,2,2, ALU_SUB)));
    tbl.push_back(V("CMPI", 16'hB105, 2'b00, 3'b000, 1'b1, E(1,0,1,0,1,0, 0,0,2,2, ALU_CMP)));
    tbl.push_back(V("LUI",  16'hF1AB, 2'b00, 3'b000, 1'b0, E(1,1,0,0,0,0, 0,0,0,3, 4'd0)));
    tbl.push_back(V("LSH",  16'h8142, 2'b00, 3'b000, 1'b1, E(1,1,0,0,1,0, 0,0,0,2, ALU_LSH)));
    tbl.push_back(V("LSHI", 16'h8103, 2'b00, 3'b000, 1'b1, E(1,1,0,0,1,0, 0,0,1,2, ALU_LSH)));
    tbl.push_back(V("JAL",  16'h4183, 2'b00, 3'b000, 1'b0, E(1,1,0,0,0,0, 1,0,0,1, 4'd0)));
    tbl.push_back(V("JUC",  16'h4EC3, 2'b00, 3'b000, 1'b0, E(1,0,0,0,0,0, 1,0,0,0, 4'd0)));
    tbl.push_back(V("JNV",  16'h4FC3, 2'b11, 3'b111, 1'b0, E(1,0,0,0,0,0, 0,0,0,0, 4'd0)));
    tbl.push_back(V("CMP",  16'h01B3, 2'b00, 3'b000, 1'b1, E(1,0,1,0,1,0, 0,0,0,2, ALU_CMP)));
    tbl.push_back(V("BEQ1", 16'hC005, 2'b00, 3'b100, 1'b1, E(1,0,0,0,0,1, 2,0,2,0, ALU_ADD)));
    tbl.push_back(V("CMP",  16'h01B3, 2'b00, 3'b000, 1'b1, E(1,0,1,0,1,0, 0,0,0,2, ALU_CMP)));
    tbl.push_back(V("BEQ0", 16'hC005, 2'b00, 3'b000, 1'b1, E(1,0,0,0,0,1, 0,0,2,0, ALU_ADD)));
    tbl.push_back(V("BNE",  16'hC1FE, 2'b00, 3'b000, 1'b1, E(1,0,0,0,0,1, 2,0,2,0, ALU_ADD)));
`ifndef CTRL_ILLEGAL_TRAP_EN
    tbl.push_back(V("BADX", 16'h0103, 2'b00, 3'b000, 1'b0, E(1,0,0,0,0,0, 0,0,0,0, 4'd0)));
`endif

    repeat (3) @(negedge clk);
    chk("reset_outputs", act, '0);
    reset = 1'b0;
    last_dec = cyc;
    #1 chk("fetch_outputs", act, '0);
    do_instr(addi, 1);

    foreach (tbl[i]) do_instr(tbl[i], 3);

    // LOAD: EXEC then LD_WB, next DECODE 4 cycles later
    m0 = memw_cnt;
    do_instr(V("LOAD", 16'h4203, 2'b00, 3'b000, 1'b0, E(0,0,0,0,0,0, 0,1,0,0, 4'd0)), 3);
    @(negedge clk);
    @(negedge clk);
    e = E(1,1,0,0,0,0, 0,1,0,0, last_alu);
    chk("ld_wb_outputs", act, e);
    do_instr(addi, 4);
    chk("load_no_memw", memw_cnt - m0, 0);

    m0 = memw_cnt;
    do_instr(V("STOR", 16'h4243, 2'b00, 3'b000, 1'b0, E(1,0,0,1,0,0, 0,1,0,0, 4'd0)), 3);
    do_instr(tbl[0], 3);
    chk("stor_memw_cycles", memw_cnt - m0, 1);

    // Reset landing in LD_WB: no register write, restart from FETCH
    do_instr(V("LOAD", 16'h4203, 2'b00, 3'b000, 1'b0, E(0,0,0,0,0,0, 0,1,0,0, 4'd0)), 3);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_in_ldwb", act, '0);
    @(negedge clk);
    reset = 1'b0;
    last_dec = cyc;
    #1 chk("fetch_after_reset", act, '0);
    do_instr(addi, 1);

    // Condition sweep through Jcond: every code against every flag combination
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 32; f++) begin
        logic [3:0] cc;
        logic [4:0] ff;
        cc = c[3:0];
        ff = f[4:0];
        v = V("JCOND", {4'h4, cc, 4'hC, 4'h3}, ff[4:3], ff[2:0], 1'b0,
              E(1,0,0,0,0,0, cref(cc, ff[4:3], ff[2:0]) ? 2'd1 : 2'd0, 0,0,0, 4'd0));
        do_instr(v, 3);
      end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    do_instr(V("OP0011", 16'h3123, 2'b00, 3'b000, 1'b0, E(0,0,0,0,0,0, 0,0,0,0, 4'd0)), 3);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      e = '0;
      e.halted = 1'b1;
      e.aluop  = last_alu;
      chk("halt_state", act, e);
    end
`else
    do_instr(V("OP0011", 16'h3123, 2'b00, 3'b000, 1'b0, E(1,0,0,0,0,0, 0,0,0,0, 4'd0)), 3);
    do_instr(addi, 3);
`endif
    @(negedge clk);
    @(negedge clk);
    chk("memw2_never", {31'd0, w2_seen}, 32'd0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
